// File: rtl/k052109_vram_arb.sv
// k052109 tile-generator VRAM port arbiter.
// Four 2-cycle windows per 8-cycle character period: video > scroll > CPU.
module k052109_vram_arb #(
  parameter int AW = 13,
  parameter int DW = 16
) (
  input  logic          M24,
  input  logic          RES,
  input  logic          CHAR_STB,
  input  logic          FETCH_REQ,
  input  logic [AW-1:0] FETCH_ADDR,
  output logic [DW-1:0] FETCH_DATA,
  output logic          FETCH_VALID,
  output logic [1:0]    FETCH_LAYER,
  input  logic          SCRL_REQ,
  input  logic [AW-1:0] SCRL_ADDR,
  output logic [DW-1:0] SCRL_DATA,
  output logic          SCRL_VALID,
  input  logic          CPU_REQ,
  input  logic          CPU_WR,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic          CPU_BSEL,
  input  logic [7:0]    CPU_WDATA,
  output logic [7:0]    CPU_RDATA,
  output logic          CPU_ACK,
  input  logic          WRP,
  output logic [AW-1:0] RA,
  input  logic [DW-1:0] VD_IN,
  output logic [DW-1:0] VD_OUT,
  output logic          VD_DRV,
  output logic [1:0]    RCS,
  output logic          ROE,
  output logic          RWE
);

  typedef enum logic [1:0] {
    G_IDLE,
    G_VID,
    G_SCRL,
    G_CPU
  } gnt_t;

  gnt_t          gnt_q;
  gnt_t          gnt_d;
  logic [2:0]    slot_q;
  logic [2:0]    slot;
  logic          cyc_a;
  logic          in_b;
  logic          cpu_pend;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [1:0]    layer_q;
  logic          wr_q;
  logic          bsel_q;
  logic [7:0]    wdata_q;

  assign slot  = CHAR_STB ? 3'd0 : slot_q;
  assign cyc_a = ~slot[0];
  assign in_b  = ~cyc_a && (gnt_q != G_IDLE);

  // The ACK cycle still sees CPU_REQ high; don't grant it a second time.
  assign cpu_pend = CPU_REQ && !CPU_ACK;

  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      gnt_q  <= G_IDLE;
      slot_q <= 3'd0;
    end else begin
      gnt_q  <= gnt_d;
      slot_q <= slot + 3'd1;
    end
  end

  always_comb begin
    gnt_d  = G_IDLE;
    addr_d = addr_q;
    RA     = addr_q;
    RCS    = 2'b11;
    ROE    = 1'b1;
    RWE    = 1'b1;
    VD_DRV = 1'b0;
    VD_OUT = '0;
    if (cyc_a && !RES) begin
      if (slot[2:1] != 2'd3 && FETCH_REQ) begin
        gnt_d  = G_VID;
        addr_d = FETCH_ADDR;
      end else if (SCRL_REQ) begin
        gnt_d  = G_SCRL;
        addr_d = SCRL_ADDR;
      end else if (cpu_pend) begin
        gnt_d  = G_CPU;
        addr_d = CPU_ADDR;
      end
      RA = addr_d;
      unique case (gnt_d)
        G_VID, G_SCRL: begin
          RCS = 2'b00;
          ROE = 1'b0;
        end
        G_CPU: begin
          RCS = CPU_BSEL ? 2'b01 : 2'b10;
          if (CPU_WR) begin
            VD_DRV = 1'b1;
            VD_OUT = {(DW/8){CPU_WDATA}};
            RWE    = WRP;
          end else begin
            ROE = 1'b0;
          end
        end
        G_IDLE: ;
      endcase
    end else if (in_b) begin
      unique case (gnt_q)
        G_VID, G_SCRL: begin
          RCS = 2'b00;
          ROE = 1'b0;
        end
        G_CPU: begin
          RCS = bsel_q ? 2'b01 : 2'b10;
          if (wr_q) begin
            VD_DRV = 1'b1;
            VD_OUT = {(DW/8){wdata_q}};
          end else begin
            ROE = 1'b0;
          end
        end
        G_IDLE: ;
      endcase
    end
  end

  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      addr_q      <= '0;
      layer_q     <= 2'd0;
      wr_q        <= 1'b0;
      bsel_q      <= 1'b0;
      wdata_q     <= 8'd0;
      FETCH_DATA  <= '0;
      FETCH_VALID <= 1'b0;
      FETCH_LAYER <= 2'd0;
      SCRL_DATA   <= '0;
      SCRL_VALID  <= 1'b0;
      CPU_RDATA   <= 8'd0;
      CPU_ACK     <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (cyc_a && gnt_d != G_IDLE) begin
        layer_q <= slot[2:1];
        wr_q    <= CPU_WR;
        bsel_q  <= CPU_BSEL;
        wdata_q <= CPU_WDATA;
      end
      FETCH_VALID <= in_b && gnt_q == G_VID;
      SCRL_VALID  <= in_b && gnt_q == G_SCRL;
      CPU_ACK     <= in_b && gnt_q == G_CPU;
      if (in_b && gnt_q == G_VID) begin
        FETCH_DATA  <= VD_IN;
        FETCH_LAYER <= layer_q;
      end
      if (in_b && gnt_q == G_SCRL)
        SCRL_DATA <= VD_IN;
      if (in_b && gnt_q == G_CPU && !wr_q)
        CPU_RDATA <= bsel_q ? VD_IN[DW-1 -: 8] : VD_IN[7:0];
    end
  end

endmodule

// File: tb/tb_k052109_vram_arb.sv
// Bench for k052109_vram_arb: directed scenarios plus a
// randomized run against a window-schedule reference model.
module tb_k052109_vram_arb;

  logic        M24 = 1'b0;
  logic        RES;
  logic        CHAR_STB;
  logic        FETCH_REQ;
  logic [12:0] FETCH_ADDR;
  logic [15:0] FETCH_DATA;
  logic        FETCH_VALID;
  logic [1:0]  FETCH_LAYER;
  logic        SCRL_REQ;
  logic [12:0] SCRL_ADDR;
  logic [15:0] SCRL_DATA;
  logic        SCRL_VALID;
  logic        CPU_REQ;
  logic        CPU_WR;
  logic [12:0] CPU_ADDR;
  logic        CPU_BSEL;
  logic [7:0]  CPU_WDATA;
  logic [7:0]  CPU_RDATA;
  logic        CPU_ACK;
  logic        WRP;
  logic [12:0] RA;
  logic [15:0] VD_IN;
  logic [15:0] VD_OUT;
  logic        VD_DRV;
  logic [1:0]  RCS;
  logic        ROE;
  logic        RWE;

  int total = 0;
  int bad   = 0;

  localparam int K_NONE = 0;
  localparam int K_VID  = 1;
  localparam int K_SCRL = 2;
  localparam int K_CPU  = 3;

  k052109_vram_arb dut (
    .M24(M24), .RES(RES), .CHAR_STB(CHAR_STB),
    .FETCH_REQ(FETCH_REQ), .FETCH_ADDR(FETCH_ADDR),
    .FETCH_DATA(FETCH_DATA), .FETCH_VALID(FETCH_VALID),
    .FETCH_LAYER(FETCH_LAYER),
    .SCRL_REQ(SCRL_REQ), .SCRL_ADDR(SCRL_ADDR),
    .SCRL_DATA(SCRL_DATA), .SCRL_VALID(SCRL_VALID),
    .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR), .CPU_ADDR(CPU_ADDR),
    .CPU_BSEL(CPU_BSEL), .CPU_WDATA(CPU_WDATA),
    .CPU_RDATA(CPU_RDATA), .CPU_ACK(CPU_ACK), .WRP(WRP),
    .RA(RA), .VD_IN(VD_IN), .VD_OUT(VD_OUT), .VD_DRV(VD_DRV),
    .RCS(RCS), .ROE(ROE), .RWE(RWE)
  );

  always #5 M24 = ~M24;

  task automatic tick();
    @(posedge M24);
    #1;
  endtask

  task automatic clear_inputs();
    CHAR_STB = 0; FETCH_REQ = 0; FETCH_ADDR = 0;
    SCRL_REQ = 0; SCRL_ADDR = 0;
    CPU_REQ = 0; CPU_WR = 0; CPU_ADDR = 0;
    CPU_BSEL = 0; CPU_WDATA = 0; WRP = 0; VD_IN = 0;
  endtask

  // Leaves the bench at cycle 0 (slot 0) with reset released.
  task automatic do_reset();
    RES = 1;
    clear_inputs();
    repeat (2) tick();
    RES = 0;
  endtask

  task automatic test_reset();
    do_reset();
    FETCH_REQ = 1; FETCH_ADDR = 13'h1ABC; VD_IN = 16'hFFFF;
    CPU_REQ = 1; CPU_WR = 1; CPU_ADDR = 13'h0F0F; CPU_WDATA = 8'h77;
    CHAR_STB = 1;
    repeat (3) begin
      tick();
      CHAR_STB = 0;
    end
    #1 RES = 1;
    #1;
    total++;
    if ({RA, RCS, ROE, RWE, VD_DRV} !== {13'h0, 2'b11, 3'b110}) begin
      bad++;
      $display("FAIL rst_pins got=%h/%b/%b%b%b exp=0000/11/110",
               RA, RCS, ROE, RWE, VD_DRV);
    end
    total++;
    if (VD_OUT !== 16'h0) begin
      bad++;
      $display("FAIL rst_vdout got=%h exp=0000", VD_OUT);
    end
    total++;
    if ({FETCH_VALID, SCRL_VALID, CPU_ACK} !== 3'b000) begin
      bad++;
      $display("FAIL rst_strobes got=%b exp=000",
               {FETCH_VALID, SCRL_VALID, CPU_ACK});
    end
    total++;
    if ({FETCH_DATA, SCRL_DATA, CPU_RDATA, FETCH_LAYER} !== 42'h0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h/%0d exp=0",
               FETCH_DATA, SCRL_DATA, CPU_RDATA, FETCH_LAYER);
    end
    clear_inputs();
    tick();
    RES = 0;
  endtask

  task automatic test_reset_mid_write();
    int acks;
    do_reset();
    CHAR_STB = 1; CPU_REQ = 1; CPU_WR = 1;
    CPU_ADDR = 13'h0555; CPU_WDATA = 8'h3C;
    #1;
    total++;
    if (RWE !== 1'b0) begin
      bad++;
      $display("FAIL rmw_pre_rwe got=%b exp=0", RWE);
    end
    #1 RES = 1;
    #1;
    total++;
    if ({RWE, VD_DRV, RCS} !== 4'b1011) begin
      bad++;
      $display("FAIL rmw_release got=%b%b%b exp=1011", RWE, VD_DRV, RCS);
    end
    tick();
    clear_inputs();
    RES = 0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      #3;
      if (CPU_ACK === 1'b1) acks++;
      tick();
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL rmw_no_ack got=%0d exp=0", acks);
    end
  endtask

  task automatic test_cpu_write_slot6();
    int acks;
    do_reset();
    acks = 0;
    CPU_WR = 1; CPU_ADDR = 13'h0123; CPU_WDATA = 8'h5A; CPU_BSEL = 0;
    FETCH_REQ = 1;
    for (int c = 0; c < 10; c++) begin
      CHAR_STB = (c % 8 == 0);
      CPU_REQ = (c <= 8);
      FETCH_ADDR = 13'h0100 + 13'(c);
      VD_IN = 16'h1000 + 16'(c);
      #3;
      if (CPU_ACK === 1'b1) acks++;
      if (c == 6) begin
        total++;
        if ({RA, RCS, RWE, VD_DRV} !== {13'h0123, 2'b10, 2'b01}) begin
          bad++;
          $display("FAIL w6_pins got=%h/%b/%b%b exp=0123/10/01",
                   RA, RCS, RWE, VD_DRV);
        end
        total++;
        if (VD_OUT !== 16'h5A5A) begin
          bad++;
          $display("FAIL w6_vdout got=%h exp=5a5a", VD_OUT);
        end
      end
      if (c == 7) begin
        total++;
        if ({RCS, RWE, RA} !== {2'b10, 1'b1, 13'h0123}) begin
          bad++;
          $display("FAIL w7_pins got=%b/%b/%h exp=10/1/0123", RCS, RWE, RA);
        end
      end
      if (c == 2 || c == 4 || c == 6) begin
        total++;
        if ({FETCH_VALID, FETCH_LAYER, FETCH_DATA} !==
            {1'b1, 2'(c / 2 - 1), 16'h1000 + 16'(c - 1)}) begin
          bad++;
          $display("FAIL w_fetch c=%0d got=%b/%0d/%h exp=1/%0d/%h", c,
                   FETCH_VALID, FETCH_LAYER, FETCH_DATA, c / 2 - 1,
                   16'h1000 + 16'(c - 1));
        end
      end
      if (c == 8) begin
        total++;
        if ({CPU_ACK, FETCH_VALID} !== 2'b10) begin
          bad++;
          $display("FAIL w8_ack got=%b%b exp=10", CPU_ACK, FETCH_VALID);
        end
      end
      tick();
    end
    total++;
    if (acks !== 1) begin
      bad++;
      $display("FAIL w_ackcount got=%0d exp=1", acks);
    end
  endtask

  task automatic test_scrl_then_cpu();
    do_reset();
    SCRL_ADDR = 13'h0777; CPU_ADDR = 13'h0321; CPU_WR = 0; CPU_BSEL = 0;
    for (int c = 0; c < 12; c++) begin
      CHAR_STB = (c % 8 == 0);
      FETCH_REQ = (c < 6);
      FETCH_ADDR = 13'h0200 + 13'(c);
      SCRL_REQ = (c == 6);
      CPU_REQ = (c >= 6 && c <= 10);
      VD_IN = 16'h2000 + 16'(c);
      #3;
      if (c == 6) begin
        total++;
        if ({RA, RCS, ROE} !== {13'h0777, 3'b000}) begin
          bad++;
          $display("FAIL sc6_pins got=%h/%b/%b exp=0777/00/0", RA, RCS, ROE);
        end
      end
      if (c == 8) begin
        total++;
        if ({SCRL_VALID, SCRL_DATA} !== {1'b1, 16'h2007}) begin
          bad++;
          $display("FAIL sc8_scrl got=%b/%h exp=1/2007", SCRL_VALID, SCRL_DATA);
        end
        total++;
        if ({RA, RCS, ROE} !== {13'h0321, 3'b100}) begin
          bad++;
          $display("FAIL sc8_cpu got=%h/%b/%b exp=0321/10/0", RA, RCS, ROE);
        end
      end
      if (c == 10) begin
        total++;
        if ({CPU_ACK, CPU_RDATA} !== {1'b1, 8'h09}) begin
          bad++;
          $display("FAIL sc10_ack got=%b/%h exp=1/09", CPU_ACK, CPU_RDATA);
        end
        total++;
        if (RCS !== 2'b11) begin
          bad++;
          $display("FAIL sc10_regrant got=%b exp=11", RCS);
        end
      end
      tick();
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    CPU_REQ = 1; CPU_WR = 0; CPU_ADDR = 13'h0A55; CPU_BSEL = 1;
    VD_IN = 16'hBEEF;
    for (int c = 0; c < 4; c++) begin
      CHAR_STB = (c == 0);
      CPU_REQ = (c < 3);
      #3;
      if (c < 2) begin
        total++;
        if ({RA, RCS, ROE, RWE} !== {13'h0A55, 4'b0101}) begin
          bad++;
          $display("FAIL rd_pins c=%0d got=%h/%b/%b%b exp=0a55/01/01",
                   c, RA, RCS, ROE, RWE);
        end
      end
      if (c == 2) begin
        total++;
        if ({CPU_ACK, CPU_RDATA} !== {1'b1, 8'hBE}) begin
          bad++;
          $display("FAIL rd_data got=%b/%h exp=1/be", CPU_ACK, CPU_RDATA);
        end
      end
      if (c == 3) begin
        total++;
        if (CPU_ACK !== 1'b0) begin
          bad++;
          $display("FAIL rd_ack_once got=%b exp=0", CPU_ACK);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrp();
    int acks;
    do_reset();
    acks = 0;
    WRP = 1; CPU_WR = 1; CPU_ADDR = 13'h0042; CPU_WDATA = 8'hC3; CPU_BSEL = 1;
    for (int c = 0; c < 6; c++) begin
      CHAR_STB = (c == 0);
      CPU_REQ = (c < 3);
      #3;
      if (CPU_ACK === 1'b1) acks++;
      if (c < 2) begin
        total++;
        if ({RWE, VD_DRV, RCS} !== 4'b1101) begin
          bad++;
          $display("FAIL wrp_pins c=%0d got=%b%b%b exp=1101", c, RWE, VD_DRV, RCS);
        end
      end
      tick();
    end
    total++;
    if (acks !== 1) begin
      bad++;
      $display("FAIL wrp_ackcount got=%0d exp=1", acks);
    end
  endtask

  task automatic test_resync();
    do_reset();
    FETCH_REQ = 1;
    for (int c = 0; c < 7; c++) begin
      CHAR_STB = (c == 0 || c == 3);
      FETCH_ADDR = 13'h0100 + 13'(c);
      VD_IN = 16'h3000 + 16'(c);
      #3;
      if (c == 2) begin
        total++;
        if ({FETCH_VALID, FETCH_LAYER, FETCH_DATA} !== {3'b100, 16'h3001}) begin
          bad++;
          $display("FAIL rs2_fetch got=%b/%0d/%h exp=1/0/3001",
                   FETCH_VALID, FETCH_LAYER, FETCH_DATA);
        end
      end
      if (c == 3) begin
        total++;
        if ({RA, RCS, ROE, FETCH_VALID} !== {13'h0103, 4'b0000}) begin
          bad++;
          $display("FAIL rs3_regrant got=%h/%b/%b/%b exp=0103/00/0/0",
                   RA, RCS, ROE, FETCH_VALID);
        end
      end
      if (c == 4) begin
        total++;
        if (FETCH_VALID !== 1'b0) begin
          bad++;
          $display("FAIL rs4_abort got=%b exp=0", FETCH_VALID);
        end
      end
      if (c == 5) begin
        total++;
        if ({FETCH_VALID, FETCH_LAYER, FETCH_DATA, RA} !==
            {3'b100, 16'h3004, 13'h0105}) begin
          bad++;
          $display("FAIL rs5_fetch got=%b/%0d/%h/%h exp=1/0/3004/0105",
                   FETCH_VALID, FETCH_LAYER, FETCH_DATA, RA);
        end
      end
      tick();
    end
  endtask

  // Expected pin state for a granted access in its first or second cycle.
  function automatic logic [18:0] pins_for(int kind, logic wr, logic bsel,
                                           logic [7:0] wd, bit first,
                                           logic wrp);
    logic [1:0]  rcs = 2'b11;
    logic        oe = 1, we = 1, drv = 0;
    logic [15:0] vd = 16'h0;
    if (kind == K_VID || kind == K_SCRL) begin
      rcs = 2'b00; oe = 0;
    end else if (kind == K_CPU) begin
      rcs = bsel ? 2'b01 : 2'b10;
      if (wr) begin
        drv = 1; vd = {wd, wd}; we = !(first && !wrp);
      end else begin
        oe = 0;
      end
    end
    return {rcs, oe, we, drv, vd[13:0]} ^ 19'h0 | 19'h0;
  endfunction

  task automatic test_random();
    int          m_slot, slot, kind, pend;
    int          m_layer, e_layer, n_layer;
    logic        m_wr, m_bsel;
    logic [7:0]  m_wd;
    logic [12:0] m_ra;
    logic        e_fv, e_sv, e_ack, e_rdchk, n_fv, n_sv, n_ack, n_rdchk;
    logic [15:0] e_fd, e_sd, n_fd, n_sd, x_vd;
    logic [7:0]  e_rd, n_rd;
    logic [1:0]  x_rcs;
    logic        x_oe, x_we, x_drv;
    logic [18:0] pv;
    bit          cpu_on, prev_ack;
    do_reset();
    m_slot = 7; pend = K_NONE; m_ra = 0; m_layer = 0;
    m_wr = 0; m_bsel = 0; m_wd = 0;
    e_fv = 0; e_sv = 0; e_ack = 0; e_rdchk = 0;
    e_fd = 0; e_sd = 0; e_rd = 0; e_layer = 0;
    cpu_on = 0; prev_ack = 0;
    for (int c = 0; c < 600; c++) begin
      if (prev_ack) cpu_on = 0;
      if (!cpu_on && $urandom_range(3) == 0) begin
        cpu_on = 1;
        CPU_WR = 1'($urandom); CPU_BSEL = 1'($urandom);
        CPU_ADDR = 13'($urandom); CPU_WDATA = 8'($urandom);
      end
      CPU_REQ = cpu_on;
      CHAR_STB = (c % 8 == 0) || ($urandom_range(19) == 0);
      FETCH_REQ = ($urandom_range(2) != 0);
      SCRL_REQ = ($urandom_range(3) == 0);
      FETCH_ADDR = 13'($urandom); SCRL_ADDR = 13'($urandom);
      VD_IN = 16'($urandom); WRP = 1'($urandom);
      slot = CHAR_STB ? 0 : (m_slot + 1) % 8;
      pv = pins_for(K_NONE, 0, 0, 0, 0, 0);
      x_vd = 0;
      n_fv = 0; n_sv = 0; n_ack = 0; n_rdchk = 0;
      n_fd = e_fd; n_sd = e_sd; n_rd = e_rd; n_layer = e_layer;
      if (slot % 2 == 0) begin
        kind = K_NONE;
        if (slot < 6 && FETCH_REQ) kind = K_VID;
        else if (SCRL_REQ) kind = K_SCRL;
        else if (CPU_REQ && !e_ack) kind = K_CPU;
        if (kind == K_VID) begin m_ra = FETCH_ADDR; m_layer = slot / 2; end
        if (kind == K_SCRL) m_ra = SCRL_ADDR;
        if (kind == K_CPU) begin
          m_ra = CPU_ADDR; m_wr = CPU_WR; m_bsel = CPU_BSEL; m_wd = CPU_WDATA;
        end
        pv = pins_for(kind, m_wr, m_bsel, m_wd, 1, WRP);
        if (kind == K_CPU && m_wr) x_vd = {m_wd, m_wd};
        pend = kind;
      end else begin
        pv = pins_for(pend, m_wr, m_bsel, m_wd, 0, 0);
        if (pend == K_CPU && m_wr) x_vd = {m_wd, m_wd};
        if (pend == K_VID) begin n_fv = 1; n_fd = VD_IN; n_layer = m_layer; end
        if (pend == K_SCRL) begin n_sv = 1; n_sd = VD_IN; end
        if (pend == K_CPU) begin
          n_ack = 1;
          if (!m_wr) begin
            n_rdchk = 1;
            n_rd = m_bsel ? VD_IN[15:8] : VD_IN[7:0];
          end
        end
        pend = K_NONE;
      end
      {x_rcs, x_oe, x_we, x_drv} = pv[18:14];
      m_slot = slot;
      #3;
      total++;
      if ({RA, RCS, ROE, RWE, VD_DRV} !== {m_ra, x_rcs, x_oe, x_we, x_drv}) begin
        bad++;
        $display("FAIL rnd_pins c=%0d got=%h/%b/%b%b%b exp=%h/%b/%b%b%b", c,
                 RA, RCS, ROE, RWE, VD_DRV, m_ra, x_rcs, x_oe, x_we, x_drv);
      end
      if (x_drv) begin
        total++;
        if (VD_OUT !== x_vd) begin
          bad++;
          $display("FAIL rnd_vdout c=%0d got=%h exp=%h", c, VD_OUT, x_vd);
        end
      end
      total++;
      if ({FETCH_VALID, SCRL_VALID, CPU_ACK} !== {e_fv, e_sv, e_ack}) begin
        bad++;
        $display("FAIL rnd_strobes c=%0d got=%b%b%b exp=%b%b%b", c,
                 FETCH_VALID, SCRL_VALID, CPU_ACK, e_fv, e_sv, e_ack);
      end
      if (e_fv) begin
        total++;
        if ({FETCH_DATA, FETCH_LAYER} !== {e_fd, 2'(e_layer)}) begin
          bad++;
          $display("FAIL rnd_fetch c=%0d got=%h/%0d exp=%h/%0d", c,
                   FETCH_DATA, FETCH_LAYER, e_fd, e_layer);
        end
      end
      if (e_sv) begin
        total++;
        if (SCRL_DATA !== e_sd) begin
          bad++;
          $display("FAIL rnd_scrl c=%0d got=%h exp=%h", c, SCRL_DATA, e_sd);
        end
      end
      if (e_rdchk) begin
        total++;
        if (CPU_RDATA !== e_rd) begin
          bad++;
          $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, CPU_RDATA, e_rd);
        end
      end
      prev_ack = e_ack;
      tick();
      e_fv = n_fv; e_sv = n_sv; e_ack = n_ack; e_rdchk = n_rdchk;
      e_fd = n_fd; e_sd = n_sd; e_rd = n_rd; e_layer = n_layer;
    end
  endtask

  initial begin
    RES = 1;
    clear_inputs();
    test_reset();
    test_reset_mid_write();
    test_cpu_write_slot6();
    test_scrl_then_cpu();
    test_cpu_read();
    test_wrp();
    test_resync();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
